// File: rtl/red_pitaya_pwm_pkg.sv
// Shared constants and the saturating duty adder for the PWM DAC channel.
// Constants cover the config word layout, the 16-period frame and the default period.
package red_pitaya_pwm_pkg;

  localparam int PWM_CFG_W      = 24;
  localparam int PWM_DUTY_W     = 8;
  localparam int PWM_DITHER_W   = 16;
  localparam int PWM_FRAME_LEN  = 16;
  localparam int PWM_PERIOD_DEF = 156;
  localparam int PWM_EFF_W      = PWM_DUTY_W + 1;
  localparam int PWM_K_W        = 4;

  // Nine-bit sum so duty=255 plus a dither bit cannot wrap before clamping.
  function automatic logic [PWM_EFF_W-1:0] pwm_sat_add(
    input logic [PWM_DUTY_W-1:0] duty,
    input logic                  dith,
    input logic [PWM_EFF_W-1:0]  limit
  );
    logic [PWM_EFF_W-1:0] sum;
    sum = {1'b0, duty} + {{(PWM_EFF_W-1){1'b0}}, dith};
    return (sum > limit) ? limit : sum;
  endfunction

endpackage

// File: rtl/red_pitaya_pwm_dac_if.sv
// Config/output bundle of one PWM DAC channel.
// cfg_i is a level with no valid/ready: the channel samples it only at frame end.
interface red_pitaya_pwm_dac_if;
  import red_pitaya_pwm_pkg::*;

  logic [PWM_CFG_W-1:0] cfg_i;
  logic                 pwm_o;
  logic                 frame_o;

  modport master (output cfg_i, input pwm_o, input frame_o);
  modport slave  (input cfg_i, output pwm_o, output frame_o);

endinterface

// File: rtl/red_pitaya_pwm_cnt.sv
// Period counter (cnt, 0..PERIOD-1) and period-in-frame index (k, 0..15).
// Flags the last cycle of each period and of each 16-period frame.
module red_pitaya_pwm_cnt
  import red_pitaya_pwm_pkg::*;
#(
  parameter int PERIOD = PWM_PERIOD_DEF
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [PWM_DUTY_W-1:0] cnt_o,
  output logic [PWM_K_W-1:0]    k_o,
  output logic                  period_end_o,
  output logic                  frame_end_o
);

  localparam logic [PWM_DUTY_W-1:0] CNT_LAST = PWM_DUTY_W'(PERIOD - 1);
  localparam logic [PWM_K_W-1:0]    K_LAST   = PWM_K_W'(PWM_FRAME_LEN - 1);

  logic [PWM_DUTY_W-1:0] cnt_q, cnt_d;
  logic [PWM_K_W-1:0]    k_q, k_d;
  logic                  period_end;
  logic                  frame_end;

  always_comb begin
    period_end = (cnt_q == CNT_LAST);
    frame_end  = period_end && (k_q == K_LAST);
    cnt_d      = period_end ? '0 : cnt_q + 1'b1;
    // k wraps 15->0 naturally at four bits.
    k_d        = period_end ? k_q + 1'b1 : k_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      k_q   <= '0;
    end else begin
      cnt_q <= cnt_d;
      k_q   <= k_d;
    end
  end

  assign cnt_o        = cnt_q;
  assign k_o          = k_q;
  assign period_end_o = period_end;
  assign frame_end_o  = frame_end;

endmodule

// File: rtl/red_pitaya_pwm_dac.sv
// Single-channel PWM DAC with 16-period dithering; cfg_i is loaded once per frame.
// Dithering is built only when RED_PITAYA_PWM_DITHER_EN is defined.
module red_pitaya_pwm_dac
  import red_pitaya_pwm_pkg::*;
#(
  parameter int PERIOD = PWM_PERIOD_DEF
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  red_pitaya_pwm_dac_if.slave  bus
);

  localparam logic [PWM_EFF_W-1:0] EFF_MAX = PWM_EFF_W'(PERIOD);

  logic [PWM_DUTY_W-1:0] cnt;
  logic [PWM_K_W-1:0]    k;
  logic [PWM_K_W-1:0]    k_next;
  logic                  period_end;
  logic                  frame_end;

  logic [PWM_DUTY_W-1:0] cur_duty_q, cur_duty_d;
  logic [PWM_EFF_W-1:0]  eff_q, eff_d;
  logic                  pwm_q, pwm_d;
  logic                  frame_q, frame_d;
  logic                  dith_load;
  logic                  dith_run;

  red_pitaya_pwm_cnt #(
    .PERIOD(PERIOD)
  ) u_cnt (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .cnt_o        (cnt),
    .k_o          (k),
    .period_end_o (period_end),
    .frame_end_o  (frame_end)
  );

  assign k_next = k + 1'b1;

`ifdef RED_PITAYA_PWM_DITHER_EN
  logic [PWM_DITHER_W-1:0] cur_dith_q, cur_dith_d;

  always_comb begin
    cur_dith_d = frame_end ? bus.cfg_i[PWM_DITHER_W-1:0] : cur_dith_q;
    // Period 0 of the next frame takes bit 0 straight from cfg_i, as the shadow loads on the same edge.
    dith_load  = bus.cfg_i[0];
    dith_run   = cur_dith_q[k_next];
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) cur_dith_q <= '0;
    else       cur_dith_q <= cur_dith_d;
  end
`else
  logic unused_dith;

  assign unused_dith = ^{bus.cfg_i[PWM_DITHER_W-1:0], k_next};
  assign dith_load   = 1'b0;
  assign dith_run    = 1'b0;
`endif

  always_comb begin
    cur_duty_d = cur_duty_q;
    eff_d      = eff_q;
    if (frame_end) begin
      cur_duty_d = bus.cfg_i[PWM_CFG_W-1:PWM_DITHER_W];
    end
    if (period_end) begin
      if (frame_end) eff_d = pwm_sat_add(bus.cfg_i[PWM_CFG_W-1:PWM_DITHER_W], dith_load, EFF_MAX);
      else           eff_d = pwm_sat_add(cur_duty_q, dith_run, EFF_MAX);
    end
    pwm_d   = ({1'b0, cnt} < eff_q);
    frame_d = frame_end;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cur_duty_q <= '0;
      eff_q      <= '0;
      pwm_q      <= 1'b0;
      frame_q    <= 1'b0;
    end else begin
      cur_duty_q <= cur_duty_d;
      eff_q      <= eff_d;
      pwm_q      <= pwm_d;
      frame_q    <= frame_d;
    end
  end

  assign bus.pwm_o   = pwm_q;
  assign bus.frame_o = frame_q;

endmodule

// File: tb/tb_red_pitaya_pwm_dac.sv
// Bench for red_pitaya_pwm_dac (PERIOD=156): timeline model + per-cycle scoreboard + directed literals.
// Expected counts follow RED_PITAYA_PWM_DITHER_EN when the bench is built with it.
module tb_red_pitaya_pwm_dac;
  import red_pitaya_pwm_pkg::*;

  localparam int P     = 156;
  localparam int FRAME = P * PWM_FRAME_LEN;
`ifdef RED_PITAYA_PWM_DITHER_EN
  localparam int DITH  = 1;
`else
  localparam int DITH  = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  red_pitaya_pwm_dac_if bus ();

  red_pitaya_pwm_dac #(.PERIOD(P)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  bit   chk_en = 1'b0;
  int   s      = 0;
  logic [23:0] frame_cfg [0:63];
  logic [1:0]  exp_q [$];

  // ---------------- model ----------------
  // s counts clock edges since reset release; cycle p=s-1 drives the output seen in state s.
  function automatic logic exp_pwm(input int st);
    int p, f, j, o, duty;
    logic [23:0] c;
    if (st == 0) return 1'b0;
    p = st - 1;
    f = p / FRAME;
    if (f == 0) return 1'b0;
    c    = frame_cfg[f % 64];
    j    = (p / P) % PWM_FRAME_LEN;
    o    = p % P;
    duty = int'(c[23:16]);
    if (DITH != 0) duty += int'(c[j]);
    if (duty > P) duty = P;
    return (o < duty);
  endfunction

  function automatic logic exp_frame(input int st);
    return (st > 0) && (st % FRAME == 0);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      s = 0;
    end else begin
      if (s % FRAME == FRAME - 1) frame_cfg[(s / FRAME + 1) % 64] = bus.cfg_i;
      s = s + 1;
    end
    if (chk_en) exp_q.push_back({exp_frame(s), exp_pwm(s)});
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    logic [1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      checks++;
      if ({bus.frame_o, bus.pwm_o} !== e) begin
        errors++;
        if (errors <= 20)
          $display("FAIL scoreboard t=%0t frame_o,pwm_o actual=%b expected=%b", $time,
                   {bus.frame_o, bus.pwm_o}, e);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic count_cycles(input int n, output int h);
    h = 0;
    repeat (n) begin
      @(negedge clk);
      h += int'(bus.pwm_o);
    end
  endtask

  task automatic wait_frame(output int n, output int h);
    n = 0;
    h = 0;
    forever begin
      @(posedge clk);
      @(negedge clk);
      n++;
      h += int'(bus.pwm_o);
      if (bus.frame_o) break;
      if (n > 2 * FRAME) begin
        errors++;
        $display("FAIL frame_timeout waited=%0d cycles expected<=%0d", n, 2 * FRAME);
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("reset_pwm", int'(bus.pwm_o), 0);
    chk("reset_frame", int'(bus.frame_o), 0);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n, h;
    bus.cfg_i = 24'h000000;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("init_reset_pwm", int'(bus.pwm_o), 0);
    chk("init_reset_frame", int'(bus.frame_o), 0);
    rst = 1'b0;

    // Zero config: first frame_o 2496 cycles after release, never high.
    wait_frame(n, h);
    chk("first_frame_latency", n, FRAME);
    chk("frame0_low", h, 0);
    for (int i = 0; i < 3; i++) begin
      count_cycles(FRAME, h);
      chk("zero_cfg_highs", h, 0);
      chk("zero_cfg_frame_spacing", int'(bus.frame_o), 1);
    end

    // 50% duty from reset.
    bus.cfg_i = 24'h4E0000;
    do_reset();
    wait_frame(n, h);
    chk("half_frame0_latency", n, FRAME);
    chk("half_frame0_low", h, 0);
    count_cycles(P, h);
    chk("half_period0", h, 78);
    count_cycles(FRAME - P, h);
    chk("half_rest", h, 78 * 15);

    // Alternate dither; the frame in flight keeps the old word.
    bus.cfg_i = 24'h4E5555;
    count_cycles(FRAME, h);
    chk("dith_inflight", h, 1248);
    count_cycles(P, h);
    chk("dith_period0", h, 78 + DITH);
    count_cycles(P, h);
    chk("dith_period1", h, 78);
    count_cycles(FRAME - 2 * P, h);
    chk("dith_rest", h, (DITH != 0) ? 1099 : 1092);

    // Saturation, then a single-cycle duty.
    bus.cfg_i = 24'h9CFFFF;
    count_cycles(FRAME, h);
    chk("dith_full_frame", h, (DITH != 0) ? 1256 : 1248);
    count_cycles(FRAME, h);
    chk("sat_9c", h, FRAME);
    bus.cfg_i = 24'hFF0000;
    count_cycles(FRAME, h);
    chk("sat_9c_again", h, FRAME);
    count_cycles(FRAME, h);
    chk("sat_ff", h, FRAME);
    bus.cfg_i = 24'h00FFFF;
    count_cycles(FRAME, h);
    chk("sat_ff_again", h, FRAME);
    count_cycles(P, h);
    chk("min_period0", h, DITH);
    count_cycles(FRAME - P, h);
    chk("min_rest", h, 15 * DITH);

    // Update at cycle 1000 of a frame waits for the frame_o pulse.
    bus.cfg_i = 24'h0F0000;
    count_cycles(FRAME, h);
    chk("min_full", h, 16 * DITH);
    count_cycles(1000, h);
    chk("steady_first_1000", h, 105);
    bus.cfg_i = 24'h750000;
    count_cycles(FRAME - 1000, h);
    chk("steady_after_change", h, 135);
    chk("change_frame_pulse", int'(bus.frame_o), 1);
    count_cycles(FRAME - 1, h);
    chk("new_duty_frame", h, 1872);

    // Change presented in the frame-end cycle itself is taken.
    bus.cfg_i = 24'h200000;
    count_cycles(1, h);
    chk("edge_load_last", h, 0);
    chk("edge_load_pulse", int'(bus.frame_o), 1);
    count_cycles(FRAME, h);
    chk("edge_load_frame", h, 512);

    // Reset while pwm_o is high mid-frame.
    bus.cfg_i = 24'h750000;
    count_cycles(FRAME, h);
    chk("pre_reset_frame", h, 512);
    count_cycles(50, h);
    chk("pre_reset_highs", h, 50);
    chk("pre_reset_pwm", int'(bus.pwm_o), 1);
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_pwm", int'(bus.pwm_o), 0);
    chk("midreset_frame", int'(bus.frame_o), 0);
    rst = 1'b0;
    wait_frame(n, h);
    chk("post_reset_latency", n, FRAME);
    chk("post_reset_frame0_low", h, 0);
    count_cycles(P, h);
    chk("post_reset_period0", h, 117);

    // ---------------- report ----------------
    repeat (2) @(negedge clk);
    chk_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
